// File: rtl/spi_xfer_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_xfer_ctrl_pkg : register map, control/status bit positions, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_xfer_ctrl_pkg;

    localparam logic [31:0] REG_TX   = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL = 32'h0000_0004;
    localparam logic [31:0] REG_STAT = 32'h0000_0008;
    localparam logic [31:0] REG_DIV  = 32'h0000_000C;
    localparam logic [31:0] REG_RX   = 32'h0000_0010;

    localparam int CTRL_LEN_MSB   = 4;
    localparam int CTRL_START_BIT = 8;
    localparam int CTRL_IRQEN_BIT = 9;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_xfer_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_xfer_ctrl_if : Wishbone slave bundle for the SPI transfer controller
// Rev 1.0
// ----------------------------------------------------------------------------
interface spi_xfer_ctrl_if;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic        sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;

    modport slave (
        input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
        output dat_o, ack_o
    );

    modport master (
        output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
        input  dat_o, ack_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_xfer_ctrl_clk_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_xfer_ctrl_clk_div : half-period tick generator, one tick per DIV+1 clocks
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_xfer_ctrl_clk_div #(
    parameter int DIV_W = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             en_i,
    input  wire logic [DIV_W-1:0] div_i,
    output logic                  tick_o
);

    logic [DIV_W-1:0] cnt_q;

    // Held at the reload value while idle so the first tick lands DIV+1 cycles after enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!en_i || cnt_q == '0) begin
            cnt_q <= div_i;
        end else begin
            cnt_q <= cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_xfer_ctrl : Wishbone-mapped single-shot SPI master (mode 0, LSB first)
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DIV_W     = 8
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    spi_xfer_ctrl_if.slave bus,
    output logic           spi_sclk,
    output logic           spi_cs_n,
    output logic           spi_mosi,
    input  wire logic      spi_miso,
    output logic           irq_o
);

    logic             ack_q;
    logic [31:0]      dat_o_q;
    logic [31:0]      tx_q;
    logic [4:0]       len_q;
    logic             irq_en_q;
    logic [DIV_W-1:0] div_q;

    spi_state_e       state_q;
    logic             sclk_q;
    logic             cs_n_q;
    logic [31:0]      shift_q;
    logic [31:0]      rx_sh_q;
    logic [31:0]      rx_q;
    logic [4:0]       bit_cnt_q;
    logic             done_q;

    logic             w_sel_tx, w_sel_ctrl, w_sel_stat, w_sel_div, w_sel_rx;
    logic             w_hit, w_wr, w_rd, w_busy, w_start, w_tick;
    logic [31:0]      w_rdata;
    logic [4:0]       w_rx_shamt;

    assign w_sel_tx   = (bus.adr_i == BASE_ADDR + REG_TX);
    assign w_sel_ctrl = (bus.adr_i == BASE_ADDR + REG_CTRL);
    assign w_sel_stat = (bus.adr_i == BASE_ADDR + REG_STAT);
    assign w_sel_div  = (bus.adr_i == BASE_ADDR + REG_DIV);
    assign w_sel_rx   = (bus.adr_i == BASE_ADDR + REG_RX);

    assign w_hit   = bus.cyc_i && bus.stb_i &&
                     (w_sel_tx || w_sel_ctrl || w_sel_stat || w_sel_div || w_sel_rx);
    assign w_wr    = w_hit && bus.we_i && bus.sel_i && !ack_q;
    assign w_rd    = w_hit && !bus.we_i && !ack_q;
    assign w_busy  = (state_q != ST_IDLE);
    assign w_start = w_wr && w_sel_ctrl && bus.dat_i[CTRL_START_BIT] && !w_busy;

    // Received bits enter at bit 31, so a short transfer must be right-aligned.
    assign w_rx_shamt = 5'd31 - len_q;

    always_comb begin
        w_rdata = '0;
        if (w_sel_tx) begin
            w_rdata = tx_q;
        end else if (w_sel_stat) begin
            w_rdata[STAT_BUSY_BIT] = w_busy;
            w_rdata[STAT_DONE_BIT] = done_q;
        end else if (w_sel_div) begin
            w_rdata[DIV_W-1:0] = div_q;
        end else if (w_sel_rx) begin
            w_rdata = rx_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            dat_o_q  <= '0;
            tx_q     <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            div_q    <= '0;
        end else begin
            ack_q   <= w_hit && !ack_q;
            dat_o_q <= w_rd ? w_rdata : '0;
            if (w_wr && !w_busy) begin
                if (w_sel_tx)   tx_q  <= bus.dat_i;
                if (w_sel_ctrl) len_q <= bus.dat_i[CTRL_LEN_MSB:0];
                if (w_sel_div)  div_q <= bus.dat_i[DIV_W-1:0];
            end
            if (w_wr && w_sel_ctrl) begin
                irq_en_q <= bus.dat_i[CTRL_IRQEN_BIT];
            end
        end
    end

    spi_xfer_ctrl_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_busy),
        .div_i  (div_q),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            shift_q   <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            // W1C first so the HOLD completion below takes priority in the same cycle.
            if (w_wr && w_sel_stat && bus.dat_i[STAT_DONE_BIT]) begin
                done_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        cs_n_q    <= 1'b0;
                        shift_q   <= tx_q;
                        rx_sh_q   <= '0;
                        bit_cnt_q <= '0;
                        done_q    <= 1'b0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            rx_sh_q <= {spi_miso, rx_sh_q[31:1]};
                        end else begin
                            sclk_q    <= 1'b0;
                            shift_q   <= {1'b0, shift_q[31:1]};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == len_q) state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        cs_n_q  <= 1'b1;
                        rx_q    <= rx_sh_q >> w_rx_shamt;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = !cs_n_q && shift_q[0];
    assign irq_o     = done_q && irq_en_q;
    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_o_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_xfer_ctrl : directed bench with a timing model of the SPI pin activity
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic sclk, cs_n, mosi, irq;
    logic miso_tied;
    logic miso;

    always #5 clk = ~clk;

    spi_xfer_ctrl_if bus ();

    assign miso = miso_tied ? 1'b1 : mosi;

    spi_xfer_ctrl #(
        .BASE_ADDR (32'h0000_0000),
        .DIV_W     (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .spi_sclk (sclk),
        .spi_cs_n (cs_n),
        .spi_mosi (mosi),
        .spi_miso (miso),
        .irq_o    (irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int pulses = 0;

    bit          mdl_on = 1'b0;
    int          mdl_t0, mdl_d, mdl_n;
    logic [31:0] mdl_tx;
    bit          mdl_tied;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(posedge sclk) pulses = pulses + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin levels t clocks after the start write: each phase lasts DIV+1 clocks;
    // phase 0 setup, phases 2,4..2n sclk high, phase 2n+1 hold, then cs_n released.
    function automatic logic [2:0] mdl_pins(input int t);
        int   k, b;
        logic s, c, m;
        k = t / (mdl_d + 1);
        c = (k >= 2 * mdl_n + 2);
        s = (k >= 2) && (k <= 2 * mdl_n) && (k % 2 == 0);
        b = (k <= 1) ? 0 : (k - 1) / 2;
        m = (!c && b < 32) ? mdl_tx[b] : 1'b0;
        return {s, c, m};
    endfunction

    function automatic logic [31:0] mdl_rx();
        logic [31:0] mask;
        mask = (mdl_n == 32) ? 32'hFFFF_FFFF : ((32'h1 << mdl_n) - 32'h1);
        return mdl_tied ? mask : (mdl_tx & mask);
    endfunction

    always @(negedge clk) begin
        if (mdl_on) begin
            logic [2:0] e;
            e = mdl_pins(cyc_cnt - mdl_t0);
            check("sclk", {31'd0, sclk}, {31'd0, e[2]});
            check("cs_n", {31'd0, cs_n}, {31'd0, e[1]});
            check("mosi", {31'd0, mosi}, {31'd0, e[0]});
        end
    end

    // All bus tasks are entered and left 1 time unit after a rising edge.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output bit acked);
        bus.adr_i = a; bus.dat_i = d; bus.we_i = 1'b1; bus.sel_i = 1'b1;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack_o) begin acked = 1'b1; break; end
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit acked);
        bus.adr_i = a; bus.we_i = 1'b0; bus.sel_i = 1'b1;
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
        acked = 1'b0; d = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack_o) begin acked = 1'b1; d = bus.dat_o; break; end
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
        bit acked;
        wb_write(a, d, acked);
        check(name, {31'd0, acked}, 32'd1);
    endtask

    task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        bit acked;
        logic [31:0] d;
        wb_read(a, d, acked);
        check({name, "_ack"}, {31'd0, acked}, 32'd1);
        check(name, d, exp);
    endtask

    task automatic do_start(input int d, input int n, input logic [31:0] tx,
                            input bit irq_en, input bit tied);
        bit acked;
        miso_tied = tied;
        wr(32'hC, d, "div_wr_ack");
        wr(32'h0, tx, "tx_wr_ack");
        mdl_on = 1'b0;
        pulses = 0;
        wb_write(32'h4, (n - 1) | (1 << 8) | (int'(irq_en) << 9), acked);
        check("start_ack", {31'd0, acked}, 32'd1);
        mdl_t0 = cyc_cnt; mdl_d = d; mdl_n = n; mdl_tx = tx; mdl_tied = tied;
        mdl_on = 1'b1;
    endtask

    task automatic wait_done();
        repeat ((mdl_d + 1) * (2 * mdl_n + 2) + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        bit acked;
        rst = 1'b1; miso_tied = 1'b0;
        bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.sel_i = 1'b0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",  {31'd0, bus.ack_o}, 32'd0);
        check("rst_dat",  bus.dat_o, 32'd0);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_irq",  {31'd0, irq},  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rd_check(32'h8, 32'h0, "stat_rst");
        rd_check(32'hC, 32'h0, "div_rst");

        // Basic 8-bit transfer, loopback
        do_start(1, 8, 32'hA5, 1'b0, 1'b0);
        wait_done();
        check("basic_pulses", pulses, 32'd8);
        rd_check(32'h10, mdl_rx(), "basic_rx_model");
        rd_check(32'h10, 32'hA5, "basic_rx_lit");
        rd_check(32'h8, 32'h2, "basic_stat");

        // Full-width transfer at DIV=0, MISO tied high
        do_start(0, 32, 32'h8000_0001, 1'b0, 1'b1);
        wait_done();
        check("full_pulses", pulses, 32'd32);
        rd_check(32'h10, 32'hFFFF_FFFF, "full_rx_lit");
        miso_tied = 1'b0;

        // Writes and start while busy are acked but have no effect
        do_start(1, 8, 32'h3C, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        wr(32'h0, 32'h1234, "busy_tx_ack");
        wr(32'hC, 32'h5, "busy_div_ack");
        wr(32'h4, 32'h103, "busy_start_ack");
        repeat (60) @(posedge clk);
        #1;
        check("busy_pulses", pulses, 32'd8);
        rd_check(32'h0, 32'h3C, "busy_tx_kept");
        rd_check(32'hC, 32'h1, "busy_div_kept");
        rd_check(32'h10, mdl_rx(), "busy_rx");
        rd_check(32'h8, 32'h2, "busy_stat");

        // IRQ and W1C
        do_start(0, 1, 32'h1, 1'b1, 1'b0);
        wait_done();
        check("irq_set", {31'd0, irq}, 32'd1);
        rd_check(32'h10, 32'h1, "irq_rx");
        wr(32'h8, 32'h2, "w1c_ack");
        check("irq_clr", {31'd0, irq}, 32'd0);
        rd_check(32'h8, 32'h0, "stat_after_w1c");

        // W1C committing on the very edge that completes the transfer
        do_start(0, 1, 32'h0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        wr(32'h8, 32'h2, "w1c_coinc_ack");
        check("coinc_cs_n", {31'd0, cs_n}, 32'd1);
        check("coinc_irq", {31'd0, irq}, 32'd1);
        rd_check(32'h8, 32'h2, "coinc_stat");
        rd_check(32'h10, mdl_rx(), "coinc_rx");

        // Reset in the middle of a transfer
        do_start(1, 8, 32'hFF, 1'b0, 1'b0);
        acked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sclk) begin acked = 1'b1; break; end
        end
        check("reached_shift", {31'd0, acked}, 32'd1);
        mdl_on = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
        check("midrst_sclk", {31'd0, sclk}, 32'd0);
        check("midrst_mosi", {31'd0, mosi}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rd_check(32'h8, 32'h0, "midrst_stat");
        rd_check(32'h10, 32'h0, "midrst_rx");

        // Unmapped and misaligned addresses are never acknowledged
        wb_read(32'h14, d, acked);
        check("unmapped_noack", {31'd0, acked}, 32'd0);
        wb_write(32'h3, 32'hFFFF_FFFF, acked);
        check("misaligned_noack", {31'd0, acked}, 32'd0);
        rd_check(32'h0, 32'h0, "tx_after_misaligned");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
